// File: rtl/bus_memory_pkg.sv
// Shared memory-map constants and loader state encoding for the bus_memory block.
package bus_memory_pkg;

  localparam logic [15:0] RAM_BASE      = 16'h0000;
  localparam logic [15:0] VEC_BASE      = 16'hFFFA;
  localparam int          VEC_COUNT     = 6;
  localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;
  localparam logic [7:0]  RST_VEC_LO    = 8'h00;
  localparam logic [7:0]  RST_VEC_HI    = 8'h02;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_HDR_ALO = 3'd1,
    LD_HDR_AHI = 3'd2,
    LD_HDR_LLO = 3'd3,
    LD_HDR_LHI = 3'd4,
    LD_DATA    = 3'd5,
    LD_HOLD    = 3'd6
  } ld_state_e;

  // Vector byte index 0 is 0xFFFA; the reset vector lives at 0xFFFC/0xFFFD.
  function automatic logic [7:0] vec_reset_value(input logic [2:0] idx);
    logic [7:0] val;
    case (idx)
      3'd2:    val = RST_VEC_LO;
      3'd3:    val = RST_VEC_HI;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  function automatic logic is_vec(input logic [15:0] addr);
    return (addr >= VEC_BASE);
  endfunction

endpackage

// File: rtl/bus_memory_loader.sv
// Program loader: parses a 4-byte header (address, length) then streams bytes
// into memory, finishing with a fixed hold period before releasing the core.
module mem_loader
  import bus_memory_pkg::*;
#(
  parameter int RST_HOLD = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic        load_busy,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD - 1);

  ld_state_e   state_r, state_s;
  logic [15:0] addr_r, addr_s;
  logic [15:0] count_r, count_s;
  logic [15:0] hold_r, hold_s;
  logic        xfer_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= LD_IDLE;
      addr_r  <= 16'h0000;
      count_r <= 16'h0000;
      hold_r  <= 16'h0000;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      count_r <= count_s;
      hold_r  <= hold_s;
    end
  end

  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    count_s    = count_r;
    hold_s     = hold_r;
    load_ready = 1'b0;
    load_busy  = (state_r != LD_IDLE);
    wr_en      = 1'b0;
    wr_addr    = addr_r;
    wr_data    = load_data;
    case (state_r)
      LD_HDR_ALO, LD_HDR_AHI, LD_HDR_LLO, LD_HDR_LHI, LD_DATA: load_ready = 1'b1;
      default:                                                 load_ready = 1'b0;
    endcase
    xfer_s = load_valid & load_ready;
    case (state_r)
      LD_IDLE: begin
        if (load_start) state_s = LD_HDR_ALO;
        else            state_s = LD_IDLE;
      end
      LD_HDR_ALO: begin
        if (xfer_s) begin
          addr_s  = {addr_r[15:8], load_data};
          state_s = LD_HDR_AHI;
        end else begin
          state_s = LD_HDR_ALO;
        end
      end
      LD_HDR_AHI: begin
        if (xfer_s) begin
          addr_s  = {load_data, addr_r[7:0]};
          state_s = LD_HDR_LLO;
        end else begin
          state_s = LD_HDR_AHI;
        end
      end
      LD_HDR_LLO: begin
        if (xfer_s) begin
          count_s = {count_r[15:8], load_data};
          state_s = LD_HDR_LHI;
        end else begin
          state_s = LD_HDR_LLO;
        end
      end
      LD_HDR_LHI: begin
        if (xfer_s) begin
          count_s = {load_data, count_r[7:0]};
          if (count_s == 16'h0000) begin
            state_s = LD_HOLD;
            hold_s  = HOLD_INIT;
          end else begin
            state_s = LD_DATA;
          end
        end else begin
          state_s = LD_HDR_LHI;
        end
      end
      LD_DATA: begin
        if (xfer_s) begin
          wr_en   = 1'b1;
          addr_s  = addr_r + 16'h0001;
          count_s = count_r - 16'h0001;
          if (count_r == 16'h0001) begin
            state_s = LD_HOLD;
            hold_s  = HOLD_INIT;
          end else begin
            state_s = LD_DATA;
          end
        end else begin
          state_s = LD_DATA;
        end
      end
      LD_HOLD: begin
        // hold_r counts down so HOLD occupies exactly RST_HOLD cycles
        if (hold_r == 16'h0000) begin
          state_s = LD_IDLE;
        end else begin
          hold_s  = hold_r - 16'h0001;
          state_s = LD_HOLD;
        end
      end
      default: state_s = LD_IDLE;
    endcase
  end

endmodule

// File: rtl/bus_memory.sv
// Processor-visible RAM plus vector registers, writable by the processor or
// by the program loader; the processor core is held in reset during loads.
module bus_memory
  import bus_memory_pkg::*;
#(
  parameter int RAM_AW   = 11,
  parameter int RST_HOLD = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic        load_busy,
  output logic        proc_resetn
);

  logic [7:0]  ram [0:(2**RAM_AW)-1];
  logic [7:0]  vec [0:VEC_COUNT-1];
  logic        ld_we_s;
  logic [15:0] ld_addr_s;
  logic [7:0]  ld_data_s;
  logic        we_s;
  logic [15:0] wa_s;
  logic [7:0]  wd_s;

  function automatic logic is_ram(input logic [15:0] addr);
    return ((addr - RAM_BASE) < 16'(2**RAM_AW));
  endfunction

  mem_loader #(.RST_HOLD(RST_HOLD)) u_loader (
    .clk        (clk),
    .resetn     (resetn),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .wr_en      (ld_we_s),
    .wr_addr    (ld_addr_s),
    .wr_data    (ld_data_s)
  );

  assign proc_resetn = resetn & ~load_busy;

  // Loader and processor never write together: the processor is in reset while loading.
  always_comb begin
    we_s = 1'b0;
    wa_s = address;
    wd_s = wr_data;
    if (ld_we_s) begin
      we_s = 1'b1;
      wa_s = ld_addr_s;
      wd_s = ld_data_s;
    end else if (wr_en && proc_resetn) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && we_s && is_ram(wa_s)) ram[wa_s[RAM_AW-1:0]] <= wd_s;
  end

  // Only the loader may change vectors; processor writes to them are dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < VEC_COUNT; i++) vec[i] <= vec_reset_value(3'(i));
    end else if (ld_we_s && is_vec(ld_addr_s)) begin
      vec[3'(ld_addr_s - VEC_BASE)] <= ld_data_s;
    end
  end

  always_comb begin
    rd_data = UNMAPPED_DATA;
    if (is_ram(address))      rd_data = ram[address[RAM_AW-1:0]];
    else if (is_vec(address)) rd_data = vec[3'(address - VEC_BASE)];
    else                      rd_data = UNMAPPED_DATA;
  end

endmodule

// File: doc/bus_memory.md
BUS_MEMORY -- requirements
Module: bus_memory

Interface
REQ-001 Parameter RAM_AW, default 11, is the RAM address width (2 KB at 0x0000-0x07FF).
REQ-002 Parameter RST_HOLD, default 2, is the number of cycles proc_resetn stays low after a load completes.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 address  in  16  processor bus address.
REQ-006 wr_en  in  1  processor write strobe.
REQ-007 wr_data  in  8  processor write data.
REQ-008 rd_data  out  8  read data for address.
REQ-009 load_start  in  1  single-cycle pulse that begins a program load.
REQ-010 load_valid  in  1  load_data holds a valid byte.
REQ-011 load_data  in  8  loader byte stream.
REQ-012 load_ready  out  1  block accepts load_data this cycle.
REQ-013 load_busy  out  1  a load is in progress.
REQ-014 proc_resetn  out  1  active-low reset to the processor core.

Function
REQ-015 Memory map: RAM at 0x0000-(2^RAM_AW-1); vector registers at 0xFFFA-0xFFFF; all other addresses are unmapped.
REQ-016 rd_data is a combinational, zero-latency function of address: RAM byte, vector byte, or 0xFF if unmapped.
REQ-017 A processor write occurs on the clk edge where wr_en=1 and proc_resetn=1; unmapped and vector addresses are ignored.
REQ-018 Processor writes with proc_resetn=0 are ignored.
REQ-019 Loader FSM states: IDLE, HDR_ALO, HDR_AHI, HDR_LLO, HDR_LHI, DATA, HOLD.
REQ-020 IDLE -> HDR_ALO on load_start; load_start in any other state is ignored.
REQ-021 A byte transfers on an edge with load_valid=1 and load_ready=1; load_ready=1 in all HDR_* states and in DATA, else 0.
REQ-022 The header is four bytes: start address low, start address high, length low, length high; each transfer advances one header state.
REQ-023 On leaving HDR_LHI: length=0 -> HOLD; otherwise -> DATA.
REQ-024 In DATA, each transfer writes load_data to the current load address, increments the address mod 2^16, and decrements the remaining count; the count reaching 0 -> HOLD.
REQ-025 Loader writes to the vector registers take effect; loader writes to unmapped addresses are dropped, but the address and count still advance.
REQ-026 HOLD lasts exactly RST_HOLD cycles, then -> IDLE.
REQ-027 load_busy=1 in every state except IDLE.
REQ-028 proc_resetn=0 while load_busy=1 or resetn=0; otherwise 1.
REQ-029 load_valid=0 stalls the FSM indefinitely; there is no timeout.
REQ-030 The processor reads rd_data freely while a load is in progress; the loader has no read port.

Reset
REQ-031 On resetn=0: FSM=IDLE, load_ready=0, load_busy=0, proc_resetn=0, load address and count cleared.
REQ-032 Vector reset values: 0xFFFC=0x00, 0xFFFD=0x02, all other vector bytes 0x00; RAM contents are not reset.
REQ-033 resetn=0 during a load aborts it; RAM bytes already written keep their values.

Structure
REQ-034 Package bus_memory_pkg holds the map constants (RAM base, vector base 0xFFFA, unmapped read value 0xFF, reset-vector defaults) and the loader state encoding.
REQ-035 The loader FSM is the sub-module mem_loader; it outputs a write enable, write address, and write data to the bus_memory storage.

Verification
REQ-036 After reset, address=0xFFFC -> rd_data=0x00; address=0xFFFD -> rd_data=0x02; proc_resetn=1 on the first cycle after resetn rises.
REQ-037 load_start, then bytes 00 02 03 00 A9 55 EA -> RAM[0x0200..0x0202]=A9,55,EA; proc_resetn is low from the load_start edge until RST_HOLD cycles after the last byte.
REQ-038 Load to address 0xFFFC, length 2, bytes 34 12 -> address 0xFFFC/0xFFFD read 0x34/0x12; no RAM byte changes.
REQ-039 Length 0 header -> DATA is never entered; HOLD lasts 2 cycles; load_ready is 0 in HOLD and IDLE.
REQ-040 load_valid toggled every other cycle during DATA -> only handshaked bytes are written; a load starting at 0xFFFF wraps, so the second byte lands at 0x0000.
REQ-041 wr_en=1, address 0x0010, wr_data 0x5A during a load -> RAM[0x0010] unchanged; the same write after the load -> read 0x5A; address 0x4000 reads 0xFF.
